// File: rtl/can_crc_field_rx_if.sv
// Bundle of the field-checker signals between the bit-stream processor
// (master) and the CRC field receiver (slave).
interface can_crc_field_rx_if;
    logic        start;
    logic        fd_frame;
    logic        fd_iso;
    logic [3:0]  dlc;
    logic        last_bit;
    logic [2:0]  destuff_count;
    logic [14:0] crc_15;
    logic [16:0] crc_17;
    logic [20:0] crc_21;
    logic        sample_point;
    logic        sampled_bit;
    logic        stuff_bit;
    logic        busy;
    logic        done;
    logic        crc_err;
    logic        stuff_cnt_err;
    logic        form_err;
    logic [20:0] rx_crc;
    logic [2:0]  rx_stuff_cnt;

    modport master (
        output start, fd_frame, fd_iso, dlc, last_bit, destuff_count,
               crc_15, crc_17, crc_21, sample_point, sampled_bit, stuff_bit,
        input  busy, done, crc_err, stuff_cnt_err, form_err, rx_crc, rx_stuff_cnt
    );

    modport slave (
        input  start, fd_frame, fd_iso, dlc, last_bit, destuff_count,
               crc_15, crc_17, crc_21, sample_point, sampled_bit, stuff_bit,
        output busy, done, crc_err, stuff_cnt_err, form_err, rx_crc, rx_stuff_cnt
    );
endinterface

// File: rtl/can_crc_field_rx.sv
// Receive-side CRC field checker: collects the CRC field, strips and checks
// FD fixed stuff bits, decodes the ISO FD stuff count and compares the
// received CRC against the generator's value.
module can_crc_field_rx #(
    parameter bit FIXED_STUFF_CHECK = 1'b1
) (
    input logic               clk,
    input logic               rst,
    can_crc_field_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FSB, SC, CRC, DONE} state_t;

    state_t      state, state_next;

    logic        snap_fd;
    logic        snap_iso;
    logic [2:0]  snap_dcnt;
    logic [20:0] snap_crc;
    logic [4:0]  data_total;

    logic [4:0]  data_cnt;
    logic [1:0]  grp_cnt;
    logic        prev_bit;
    logic [2:0]  sc_shift;

    logic        busy_q;
    logic        done_q;
    logic        crc_err_q;
    logic        sc_err_q;
    logic        form_err_q;
    logic [20:0] rx_crc_q;
    logic [2:0]  rx_sc_q;

    logic        consume;
    logic        finishing;
    logic [20:0] rx_crc_shifted;
    logic [2:0]  sc_decoded;

    assign rx_crc_shifted = {rx_crc_q[19:0], bus.sampled_bit};
    assign sc_decoded     = {sc_shift[2],
                             sc_shift[2] ^ sc_shift[1],
                             sc_shift[2] ^ sc_shift[1] ^ sc_shift[0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: decides whether this cycle's sample is a field bit and where it leads.
    always_comb begin
        state_next = state;
        consume    = 1'b0;
        finishing  = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            FSB: begin
                if (bus.sample_point) begin
                    consume    = 1'b1;
                    state_next = (snap_iso && data_cnt < 5'd4) ? SC : CRC;
                end
            end
            SC, CRC: begin
                if (bus.sample_point && (snap_fd || !bus.stuff_bit)) begin
                    consume = 1'b1;
                    if (data_cnt + 5'd1 == data_total) begin
                        state_next = DONE;
                        finishing  = 1'b1;
                    end else if (snap_fd && grp_cnt == 2'd3) begin
                        state_next = FSB;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.start) begin
            state_next = bus.fd_frame ? FSB : CRC;
            consume    = 1'b0;
            finishing  = 1'b0;
        end
    end

    // Snapshots, counters, received values and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_fd    <= 1'b0;
            snap_iso   <= 1'b0;
            snap_dcnt  <= 3'd0;
            snap_crc   <= 21'd0;
            data_total <= 5'd0;
            data_cnt   <= 5'd0;
            grp_cnt    <= 2'd0;
            prev_bit   <= 1'b0;
            sc_shift   <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            sc_err_q   <= 1'b0;
            form_err_q <= 1'b0;
            rx_crc_q   <= 21'd0;
            rx_sc_q    <= 3'd0;
        end else if (bus.start) begin
            snap_fd   <= bus.fd_frame;
            snap_iso  <= bus.fd_frame & bus.fd_iso;
            snap_dcnt <= bus.destuff_count;
            if (!bus.fd_frame) begin
                snap_crc   <= {6'd0, bus.crc_15};
                data_total <= 5'd15;
            end else if (bus.dlc > 4'd10) begin
                snap_crc   <= bus.crc_21;
                data_total <= (bus.fd_iso ? 5'd4 : 5'd0) + 5'd21;
            end else begin
                snap_crc   <= {4'd0, bus.crc_17};
                data_total <= (bus.fd_iso ? 5'd4 : 5'd0) + 5'd17;
            end
            data_cnt   <= 5'd0;
            grp_cnt    <= 2'd0;
            prev_bit   <= bus.last_bit;
            sc_shift   <= 3'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            sc_err_q   <= 1'b0;
            form_err_q <= 1'b0;
            rx_crc_q   <= 21'd0;
            rx_sc_q    <= 3'd0;
        end else begin
            done_q <= finishing;
            busy_q <= (state_next == FSB) || (state_next == SC) || (state_next == CRC);
            if (consume) begin
                prev_bit <= bus.sampled_bit;
                if (state == FSB) begin
                    if (FIXED_STUFF_CHECK && (bus.sampled_bit == prev_bit))
                        form_err_q <= 1'b1;
                end else begin
                    data_cnt <= data_cnt + 5'd1;
                    grp_cnt  <= grp_cnt + 2'd1;
                    if (state == SC) begin
                        sc_shift <= {sc_shift[1:0], bus.sampled_bit};
                        if (data_cnt == 5'd3) begin
                            rx_sc_q  <= sc_decoded;
                            sc_err_q <= (sc_decoded != snap_dcnt) ||
                                        (^{sc_shift, bus.sampled_bit});
                        end
                    end else begin
                        rx_crc_q <= rx_crc_shifted;
                        if (finishing)
                            crc_err_q <= (rx_crc_shifted != snap_crc);
                    end
                end
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.crc_err       = crc_err_q;
    assign bus.stuff_cnt_err = sc_err_q;
    assign bus.form_err      = form_err_q;
    assign bus.rx_crc        = rx_crc_q;
    assign bus.rx_stuff_cnt  = rx_sc_q;
endmodule

// File: tb/tb_can_crc_field_rx.sv
// Testbench for can_crc_field_rx: two instances (fixed stuff check on and
// off) share one stimulus stream; a reference model predicts every field
// result and per-instance monitors compare when done pulses.
module tb_can_crc_field_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        fd_frame = 1'b0;
    logic        fd_iso = 1'b0;
    logic [3:0]  dlc = 4'd0;
    logic        last_bit = 1'b0;
    logic [2:0]  destuff_count = 3'd0;
    logic [14:0] crc_15 = 15'd0;
    logic [16:0] crc_17 = 17'd0;
    logic [20:0] crc_21 = 21'd0;
    logic        sample_point = 1'b0;
    logic        sampled_bit = 1'b0;
    logic        stuff_bit = 1'b0;

    always #5 clk = ~clk;

    can_crc_field_rx_if bus_chk ();
    can_crc_field_rx_if bus_nochk ();

    assign bus_chk.start           = start;
    assign bus_chk.fd_frame        = fd_frame;
    assign bus_chk.fd_iso          = fd_iso;
    assign bus_chk.dlc             = dlc;
    assign bus_chk.last_bit        = last_bit;
    assign bus_chk.destuff_count   = destuff_count;
    assign bus_chk.crc_15          = crc_15;
    assign bus_chk.crc_17          = crc_17;
    assign bus_chk.crc_21          = crc_21;
    assign bus_chk.sample_point    = sample_point;
    assign bus_chk.sampled_bit     = sampled_bit;
    assign bus_chk.stuff_bit       = stuff_bit;
    assign bus_nochk.start         = start;
    assign bus_nochk.fd_frame      = fd_frame;
    assign bus_nochk.fd_iso        = fd_iso;
    assign bus_nochk.dlc           = dlc;
    assign bus_nochk.last_bit      = last_bit;
    assign bus_nochk.destuff_count = destuff_count;
    assign bus_nochk.crc_15        = crc_15;
    assign bus_nochk.crc_17        = crc_17;
    assign bus_nochk.crc_21        = crc_21;
    assign bus_nochk.sample_point  = sample_point;
    assign bus_nochk.sampled_bit   = sampled_bit;
    assign bus_nochk.stuff_bit     = stuff_bit;

    can_crc_field_rx #(.FIXED_STUFF_CHECK(1'b1)) dut_chk (
        .clk (clk),
        .rst (rst),
        .bus (bus_chk.slave)
    );

    can_crc_field_rx #(.FIXED_STUFF_CHECK(1'b0)) dut_nochk (
        .clk (clk),
        .rst (rst),
        .bus (bus_nochk.slave)
    );

    typedef struct {
        bit        fd;
        bit        iso;
        bit [3:0]  dlc;
        bit        lastb;
        bit [2:0]  dcnt;
        bit [14:0] c15;
        bit [16:0] c17;
        bit [20:0] c21;
        bit [20:0] sent_crc;
        bit [2:0]  sent_gray;
        bit        sent_par;
        int        bad_fsb;
    } field_t;

    typedef struct {
        bit [20:0] rx_crc;
        bit [2:0]  rx_sc;
        bit        crc_err;
        bit        sc_err;
        bit        form_err;
        int        done_cyc;
    } exp_t;

    exp_t exp_q_chk[$];
    exp_t exp_q_nochk[$];
    bit [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string who, input exp_t e, input logic [20:0] rx_crc,
                               input logic [2:0] rx_sc, input logic crc_err, input logic sc_err,
                               input logic form_err, input logic busy);
        compare({who, " done_cycle"}, cyc, e.done_cyc);
        compare({who, " rx_crc"}, {11'd0, rx_crc}, {11'd0, e.rx_crc});
        compare({who, " rx_stuff_cnt"}, {29'd0, rx_sc}, {29'd0, e.rx_sc});
        compare({who, " crc_err"}, {31'd0, crc_err}, {31'd0, e.crc_err});
        compare({who, " stuff_cnt_err"}, {31'd0, sc_err}, {31'd0, e.sc_err});
        compare({who, " form_err"}, {31'd0, form_err}, {31'd0, e.form_err});
        compare({who, " busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor for the instance with fixed stuff checking enabled.
    initial forever begin
        @(negedge clk);
        if (bus_chk.done === 1'b1) begin
            if (exp_q_chk.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL chk unexpected_done: got done=1, expected no done");
            end else begin
                checkOutput("chk", exp_q_chk.pop_front(), bus_chk.rx_crc, bus_chk.rx_stuff_cnt,
                            bus_chk.crc_err, bus_chk.stuff_cnt_err, bus_chk.form_err, bus_chk.busy);
            end
        end
    end

    // Monitor for the instance with fixed stuff checking disabled.
    initial forever begin
        @(negedge clk);
        if (bus_nochk.done === 1'b1) begin
            if (exp_q_nochk.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL nochk unexpected_done: got done=1, expected no done");
            end else begin
                checkOutput("nochk", exp_q_nochk.pop_front(), bus_nochk.rx_crc, bus_nochk.rx_stuff_cnt,
                            bus_nochk.crc_err, bus_nochk.stuff_cnt_err, bus_nochk.form_err, bus_nochk.busy);
            end
        end
    end

    function automatic field_t make_field(input bit fd, input bit iso, input bit [3:0] dl);
        field_t f;
        f.fd    = fd;
        f.iso   = iso;
        f.dlc   = dl;
        f.lastb = 1'($urandom_range(0, 1));
        f.dcnt  = 3'($urandom_range(0, 7));
        f.c15   = 15'($urandom);
        f.c17   = 17'($urandom);
        f.c21   = 21'($urandom);
        if (!fd)            f.sent_crc = 21'(f.c15);
        else if (dl > 4'd10) f.sent_crc = f.c21;
        else                f.sent_crc = 21'(f.c17);
        f.sent_gray = gray_tab[f.dcnt];
        f.sent_par  = ^gray_tab[f.dcnt];
        f.bad_fsb   = -1;
        return f;
    endfunction

    // Builds the bit stream from the field rules, predicts the result and drives it.
    // A non-negative abort_after stops after that many stream bits without a result.
    task automatic applyStimulus(input field_t f, input int abort_after);
        bit   data_q[$];
        bit   stream_q[$];
        bit   prev;
        bit   fsb_bad;
        bit   iso_eff;
        bit   s;
        int   w;
        int   fsb_i;
        int   dec;
        bit [20:0] sel;
        exp_t e;
        iso_eff = f.fd & f.iso;
        w = !f.fd ? 15 : ((f.dlc > 4'd10) ? 21 : 17);
        if (iso_eff) begin
            data_q.push_back(f.sent_gray[2]);
            data_q.push_back(f.sent_gray[1]);
            data_q.push_back(f.sent_gray[0]);
            data_q.push_back(f.sent_par);
        end
        for (int i = w - 1; i >= 0; i--) data_q.push_back(f.sent_crc[i]);
        prev    = f.lastb;
        fsb_bad = 1'b0;
        fsb_i   = 0;
        foreach (data_q[i]) begin
            if (f.fd && (i % 4 == 0)) begin
                s = !prev;
                if (fsb_i == f.bad_fsb) begin
                    s       = prev;
                    fsb_bad = 1'b1;
                end
                stream_q.push_back(s);
                prev = s;
                fsb_i++;
            end
            stream_q.push_back(data_q[i]);
            prev = data_q[i];
        end
        if (!f.fd)               sel = 21'(f.c15);
        else if (f.dlc > 4'd10)  sel = f.c21;
        else                     sel = 21'(f.c17);
        e.rx_crc  = f.sent_crc;
        e.crc_err = (f.sent_crc != sel);
        e.rx_sc   = 3'd0;
        e.sc_err  = 1'b0;
        if (iso_eff) begin
            dec = 0;
            for (int v = 0; v < 8; v++) if (gray_tab[v] == f.sent_gray) dec = v;
            e.rx_sc  = 3'(dec);
            e.sc_err = (3'(dec) != f.dcnt) || (^{f.sent_gray, f.sent_par});
        end

        @(negedge clk);
        fd_frame      = f.fd;
        fd_iso        = f.iso;
        dlc           = f.dlc;
        last_bit      = f.lastb;
        destuff_count = f.dcnt;
        crc_15        = f.c15;
        crc_17        = f.c17;
        crc_21        = f.c21;
        start         = 1'b1;
        sample_point  = 1'($urandom_range(0, 1));
        sampled_bit   = 1'($urandom_range(0, 1));
        stuff_bit     = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        sample_point = 1'b0;
        compare("busy_after_start", {31'd0, bus_chk.busy}, 32'd1);

        foreach (stream_q[k]) begin
            if (abort_after >= 0 && k == abort_after) return;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (!f.fd && (k == 3 || k == 9 || $urandom_range(0, 5) == 0)) begin
                sample_point = 1'b1;
                stuff_bit    = 1'b1;
                sampled_bit  = 1'($urandom_range(0, 1));
                @(negedge clk);
                sample_point = 1'b0;
                stuff_bit    = 1'b0;
            end
            sample_point = 1'b1;
            sampled_bit  = stream_q[k];
            stuff_bit    = f.fd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == stream_q.size() - 1) begin
                e.done_cyc = cyc + 1;
                e.form_err = fsb_bad;
                exp_q_chk.push_back(e);
                e.form_err = 1'b0;
                exp_q_nochk.push_back(e);
            end
            @(negedge clk);
            sample_point = 1'b0;
            stuff_bit    = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        field_t f;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compare("reset busy", {31'd0, bus_chk.busy}, 32'd0);
        compare("reset done", {31'd0, bus_chk.done}, 32'd0);
        compare("reset rx_crc", {11'd0, bus_chk.rx_crc}, 32'd0);
        compare("reset flags", {29'd0, bus_chk.crc_err, bus_chk.stuff_cnt_err, bus_chk.form_err}, 32'd0);

        // Classic frame with interleaved dynamic stuff bits.
        f = make_field(1'b0, 1'b0, 4'd8);
        f.c15 = 15'h4A2C;
        f.sent_crc = 21'h004A2C;
        applyStimulus(f, -1);

        // ISO FD CRC17, stuff count 5, last data bit 0.
        f = make_field(1'b1, 1'b1, 4'd8);
        f.lastb = 1'b0;
        f.dcnt = 3'd5;
        f.sent_gray = gray_tab[5];
        f.sent_par = ^gray_tab[5];
        applyStimulus(f, -1);

        // ISO FD CRC21 with one received bit flipped.
        f = make_field(1'b1, 1'b1, 4'd13);
        f.sent_crc = f.c21 ^ (21'd1 << $urandom_range(0, 20));
        applyStimulus(f, -1);

        // Non-ISO FD CRC17 with the third FSB equal to the preceding bit.
        f = make_field(1'b1, 1'b0, 4'd4);
        f.bad_fsb = 2;
        applyStimulus(f, -1);

        // Stuff count 3 received as Gray 010 with bad then good parity.
        f = make_field(1'b1, 1'b1, 4'd6);
        f.dcnt = 3'd3;
        f.sent_gray = 3'b010;
        f.sent_par = 1'b0;
        applyStimulus(f, -1);
        f.sent_par = 1'b1;
        applyStimulus(f, -1);

        // Reset mid-field, then a full field.
        f = make_field(1'b1, 1'b1, 4'd12);
        applyStimulus(f, 10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compare("midreset busy", {31'd0, bus_chk.busy}, 32'd0);
        compare("midreset rx_crc", {11'd0, bus_chk.rx_crc}, 32'd0);
        compare("midreset rx_stuff_cnt", {29'd0, bus_chk.rx_stuff_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(f, -1);

        // Restart mid-field, then a full field of a different kind.
        f = make_field(1'b1, 1'b0, 4'd14);
        applyStimulus(f, 12);
        f = make_field(1'b0, 1'b1, 4'd2);
        applyStimulus(f, 7);
        f = make_field(1'b1, 1'b1, 4'd9);
        applyStimulus(f, -1);

        // Random fields with random corruption.
        for (int n = 0; n < 40; n++) begin
            f = make_field(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) f.sent_crc = f.sent_crc ^ (21'd1 << $urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) f.bad_fsb = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) f.sent_gray = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) f.sent_par = ~f.sent_par;
            applyStimulus(f, -1);
        end

        for (int i = 0; i < 50 && (exp_q_chk.size() != 0 || exp_q_nochk.size() != 0); i++)
            @(negedge clk);
        if (exp_q_chk.size() != 0 || exp_q_nochk.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL missing_done: got %0d/%0d pending results, expected 0",
                     exp_q_chk.size(), exp_q_nochk.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
